jtag_tap_responder: RTL and testbench

//  IEEE 1149.1 TAP responder (target end of JTAG) for CPLD user designs; companion to host-side JTAG initiators.
//  TCK/TMS/TDI are oversampled in the CLK domain; 16-state TAP FSM, IR, BYPASS/IDCODE DRs, user-DR strobe port.

---
 rtl/jtag_pkg.sv | 52 +++++
 rtl/jtag_pin_sync.sv | 39 +++
 rtl/jtag_tap_responder.sv | 163 ++++++++++++++++
 tb/tb_jtag_tap_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP state encoding, DR selection codes and the 1149.1 next-state function.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR     = 4'hF,
        RTI     = 4'hC,
        SELDR   = 4'h7,
        CAPDR   = 4'h6,
        SHDR    = 4'h2,
        EX1DR   = 4'h1,
        PAUSEDR = 4'h3,
        EX2DR   = 4'h0,
        UPDDR   = 4'h5,
        SELIR   = 4'h4,
        CAPIR   = 4'hE,
        SHIR    = 4'hA,
        EX1IR   = 4'h9,
        PAUSEIR = 4'hB,
        EX2IR   = 4'h8,
        UPDIR   = 4'hD
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USERCODE,
        DR_USER
    } dr_sel_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        case (s)
            TLR:     tap_next = tms ? TLR   : RTI;
            RTI:     tap_next = tms ? SELDR : RTI;
            SELDR:   tap_next = tms ? SELIR : CAPDR;
            CAPDR:   tap_next = tms ? EX1DR : SHDR;
            SHDR:    tap_next = tms ? EX1DR : SHDR;
            EX1DR:   tap_next = tms ? UPDDR : PAUSEDR;
            PAUSEDR: tap_next = tms ? EX2DR : PAUSEDR;
            EX2DR:   tap_next = tms ? UPDDR : SHDR;
            UPDDR:   tap_next = tms ? SELDR : RTI;
            SELIR:   tap_next = tms ? TLR   : CAPIR;
            CAPIR:   tap_next = tms ? EX1IR : SHIR;
            SHIR:    tap_next = tms ? EX1IR : SHIR;
            EX1IR:   tap_next = tms ? UPDIR : PAUSEIR;
            PAUSEIR: tap_next = tms ? EX2IR : PAUSEIR;
            EX2IR:   tap_next = tms ? UPDIR : SHIR;
            UPDIR:   tap_next = tms ? SELDR : RTI;
            default: tap_next = TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// Brings the JTAG pins into the CLK domain: 2-FF synchronisers plus a TCK edge
// detector producing single-CLK rise/fall pulses aligned with the synced TMS/TDI.
module jtag_pin_sync (
    input  logic CLK,
    input  logic RST,
    input  logic tck_pin,
    input  logic tms_pin,
    input  logic tdi_pin,
    output logic rise,
    output logic fall,
    output logic tms,
    output logic tdi
);

    logic [1:0] tck_sync;
    logic [1:0] tms_sync;
    logic [1:0] tdi_sync;
    logic       tck_prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_prev <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[0], tck_pin};
            tms_sync <= {tms_sync[0], tms_pin};
            tdi_sync <= {tdi_sync[0], tdi_pin};
            tck_prev <= tck_sync[1];
        end
    end

    assign rise = tck_sync[1] & ~tck_prev;
    assign fall = ~tck_sync[1] & tck_prev;
    assign tms  = tms_sync[1];
    assign tdi  = tdi_sync[1];

endmodule

// File: rtl/jtag_tap_responder.sv
// JTAG TAP target: oversampled TAP FSM, IR, BYPASS/IDCODE DRs and a user-DR strobe port.
// Define JTAG_TAP_USERCODE_EN to give OP_USERCODE its own 32-bit USERCODE register.
//
//  state   | meaning
//  TLR     | test-logic-reset, IR forced to OP_IDCODE
//  RTI     | run-test/idle
//  SELDR   | select DR column
//  CAPDR   | capture selected DR on next TCK rise
//  SHDR    | shift selected DR, TDO driven
//  EX1DR   | exit-1 DR
//  PAUSEDR | pause DR shift
//  EX2DR   | exit-2 DR
//  UPDDR   | update DR (user strobe only)
//  SELIR   | select IR column
//  CAPIR   | capture 0..01 into IR shift reg
//  SHIR    | shift IR, TDO driven
//  EX1IR   | exit-1 IR
//  PAUSEIR | pause IR shift
//  EX2IR   | exit-2 IR
//  UPDIR   | IR loaded from IR shift reg
module jtag_tap_responder
    import jtag_pkg::*;
#(
    parameter int                 IR_LEN      = 4,
    parameter logic [31:0]        IDCODE      = 32'h0150203F,
    parameter logic [IR_LEN-1:0]  OP_IDCODE   = IR_LEN'(1),
    parameter logic [IR_LEN-1:0]  OP_USERCODE = IR_LEN'(2),
    parameter logic [31:0]        USERCODE    = 32'h00000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TCK,
    input  logic              TMS,
    input  logic              TDI,
    output logic              TDO,
    output logic              TDO_OE,
    output logic [3:0]        STATE,
    output logic [IR_LEN-1:0] IR,
    output logic              DR_CAPTURE,
    output logic              DR_SHIFT,
    output logic              DR_UPDATE,
    output logic              DR_TDI,
    input  logic              DR_TDO
);

`ifdef JTAG_TAP_USERCODE_EN
    localparam bit USERCODE_EN = 1'b1;
`else
    localparam bit USERCODE_EN = 1'b0;
`endif

    logic              rise;
    logic              fall;
    logic              tms_s;
    logic              tdi_s;
    tap_state_t        state;
    tap_state_t        state_d;
    dr_sel_t           dr_sel;
    logic              is_user;
    logic [IR_LEN-1:0] ir;
    logic [IR_LEN-1:0] ir_sr;
    logic [31:0]       dr_sr;
    logic              byp_sr;
    logic              tdo_d;

    jtag_pin_sync u_sync (
        .CLK     (CLK),
        .RST     (RST),
        .tck_pin (TCK),
        .tms_pin (TMS),
        .tdi_pin (TDI),
        .rise    (rise),
        .fall    (fall),
        .tms     (tms_s),
        .tdi     (tdi_s)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= TLR;
        end else if (rise) begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = tap_next(state, tms_s);
        dr_sel  = DR_USER;
        if (ir == OP_IDCODE) begin
            dr_sel = DR_IDCODE;
        end else if (&ir) begin
            dr_sel = DR_BYPASS;
        end else if (USERCODE_EN && (ir == OP_USERCODE)) begin
            dr_sel = DR_USERCODE;
        end
        is_user = (dr_sel == DR_USER);
    end

    // The IR column must present the IR shift reg regardless of the active instruction.
    always_comb begin
        tdo_d = 1'b0;
        if (state inside {CAPIR, SHIR, EX1IR, PAUSEIR, EX2IR, UPDIR}) begin
            tdo_d = ir_sr[0];
        end else begin
            case (dr_sel)
                DR_IDCODE, DR_USERCODE: tdo_d = dr_sr[0];
                DR_BYPASS:              tdo_d = byp_sr;
                default:                tdo_d = DR_TDO;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ir         <= OP_IDCODE;
            ir_sr      <= '0;
            dr_sr      <= '0;
            byp_sr     <= 1'b0;
            TDO        <= 1'b0;
            TDO_OE     <= 1'b0;
            DR_CAPTURE <= 1'b0;
            DR_SHIFT   <= 1'b0;
            DR_UPDATE  <= 1'b0;
            DR_TDI     <= 1'b0;
        end else begin
            DR_CAPTURE <= 1'b0;
            DR_SHIFT   <= 1'b0;
            DR_UPDATE  <= 1'b0;
            if (rise) begin
                case (state)
                    CAPIR: ir_sr <= IR_LEN'(1);
                    SHIR:  ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
                    CAPDR: begin
                        dr_sr      <= (dr_sel == DR_USERCODE) ? USERCODE : IDCODE;
                        byp_sr     <= 1'b0;
                        DR_CAPTURE <= is_user;
                    end
                    SHDR: begin
                        dr_sr    <= {tdi_s, dr_sr[31:1]};
                        byp_sr   <= tdi_s;
                        DR_SHIFT <= is_user;
                        DR_TDI   <= tdi_s;
                    end
                    default: ;
                endcase
                if (state_d == UPDIR) begin
                    ir <= ir_sr;
                end else if (state_d == TLR) begin
                    ir <= OP_IDCODE;
                end
                DR_UPDATE <= (state_d == UPDDR) && is_user;
            end
            if (fall) begin
                TDO    <= tdo_d;
                TDO_OE <= (state == SHDR) || (state == SHIR);
            end
        end
    end

    assign STATE = state;
    assign IR    = ir;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: IDCODE/IR/BYPASS scans, TLR escape, user-DR strobes.
module tb_jtag_tap_responder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TCK = 1'b0;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       DR_TDO = 1'b0;
    logic       TDO, TDO_OE, DR_CAPTURE, DR_SHIFT, DR_UPDATE, DR_TDI;
    logic [3:0] STATE;
    logic [3:0] IR;

    int checks = 0;
    int errors = 0;
    int cap_cnt = 0;
    int sh_cnt = 0;
    int upd_cnt = 0;
    logic [7:0] tdi_log = '0;

    jtag_tap_responder dut (
        .CLK(CLK), .RST(RST), .TCK(TCK), .TMS(TMS), .TDI(TDI),
        .TDO(TDO), .TDO_OE(TDO_OE), .STATE(STATE), .IR(IR),
        .DR_CAPTURE(DR_CAPTURE), .DR_SHIFT(DR_SHIFT), .DR_UPDATE(DR_UPDATE),
        .DR_TDI(DR_TDI), .DR_TDO(DR_TDO)
    );

    always #5 CLK = ~CLK;

    // Strobe cycle counters: a strobe wider than one CLK over-counts.
    always @(posedge CLK) begin
        if (DR_CAPTURE) cap_cnt <= cap_cnt + 1;
        if (DR_UPDATE)  upd_cnt <= upd_cnt + 1;
        if (DR_SHIFT) begin
            sh_cnt  <= sh_cnt + 1;
            tdi_log <= {tdi_log[6:0], DR_TDI};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tck(input logic tms_v, input logic tdi_v);
        TMS = tms_v;
        TDI = tdi_v;
        repeat (4) @(negedge CLK);
        TCK = 1'b1;
        repeat (4) @(negedge CLK);
        TCK = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic tck_lat(input logic tms_v, input logic [3:0] st_old,
                           input logic [3:0] st_new, input string tag);
        TMS = tms_v;
        repeat (4) @(negedge CLK);
        TCK = 1'b1;
        repeat (2) @(negedge CLK);
        check({tag, "_pre"}, STATE, st_old);
        @(negedge CLK);
        check({tag, "_post"}, STATE, st_new);
        repeat (2) @(negedge CLK);
        TCK = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        logic [31:0] id_got;
        logic [3:0]  ir_got;
        logic [8:0]  byp_got;
        logic [7:0]  pat;
        logic [3:0]  op;
        logic [2:0]  dpat;
        logic [2:0]  tpat;
        int c0, s0, u0;

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_state", STATE, 4'hF);
        check("rst_ir", IR, 4'h1);
        check("rst_tdo_oe", TDO_OE, 1'b0);
        check("rst_tdo", TDO, 1'b0);
        check("rst_strobes", {DR_CAPTURE, DR_SHIFT, DR_UPDATE}, 3'b000);

        tck_lat(1'b0, 4'hF, 4'hC, "lat_rti");

        // IDCODE scan
        tck(1, 0); tck(0, 0); tck(0, 0);
        check("id_state_shdr", STATE, 4'h2);
        check("id_tdo_oe_on", TDO_OE, 1'b1);
        for (int i = 0; i < 32; i++) begin
            id_got[i] = TDO;
            tck(i == 31, 1'b0);
        end
        check("id_value", id_got, 32'h0150203F);
        check("id_tdo_oe_off", TDO_OE, 1'b0);
        tck(1, 0); tck(0, 0);
        check("id_back_rti", STATE, 4'hC);

        // IR scan loading all-ones
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        check("ir_state_shir", STATE, 4'hA);
        for (int i = 0; i < 4; i++) begin
            ir_got[i] = TDO;
            tck(i == 3, 1'b1);
        end
        check("ir_capture", ir_got, 4'b0001);
        tck(1, 0);
        check("ir_update_byp", IR, 4'hF);
        tck(0, 0);

        // BYPASS
        pat = 8'hA5;
        tck(1, 0); tck(0, 0); tck(0, 0);
        for (int i = 0; i < 9; i++) begin
            byp_got[i] = TDO;
            tck(i == 8, (i < 8) ? pat[i] : 1'b0);
        end
        check("byp_data", byp_got, 9'h14A);
        tck(1, 0); tck(0, 0);
        check("no_user_strobes", cap_cnt + sh_cnt + upd_cnt, 0);

        // Escape to TLR from Shift-DR
        tck(1, 0); tck(0, 0); tck(0, 0);
        tck(1, 0); tck(1, 0); tck(1, 0); tck(1, 0);
        check("tlr_4th", STATE, 4'h4);
        tck_lat(1'b1, 4'h4, 4'hF, "tlr_5th");
        check("tlr_ir", IR, 4'h1);

        // Load user opcode 4'h3
        op = 4'h3;
        tck(0, 0); tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        for (int i = 0; i < 4; i++) tck(i == 3, op[i]);
        tck(1, 0);
        check("user_ir", IR, 4'h3);
        check("user_updir", STATE, 4'hD);
        tck(0, 0);

        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        tck(1, 0); tck(0, 0); tck(0, 0);
        check("user_capture", cap_cnt - c0, 1);
        check("user_no_shift_yet", sh_cnt - s0, 0);
        check("user_tdo_oe", TDO_OE, 1'b1);
        dpat = 3'b011;
        tpat = 3'b011;
        for (int i = 0; i < 3; i++) begin
            DR_TDO = dpat[i];
            tck(i == 2, tpat[i]);
            check($sformatf("user_tdo_%0d", i), TDO, dpat[i]);
        end
        check("user_shift_cnt", sh_cnt - s0, 3);
        check("user_dr_tdi", tdi_log[2:0], 3'b110);
        check("user_no_update_yet", upd_cnt - u0, 0);
        tck(1, 0);
        check("user_update", upd_cnt - u0, 1);
        check("user_upddr", STATE, 4'h5);
        tck(0, 0);

        // Reset in the middle of a user shift
        tck(1, 0); tck(0, 0); tck(0, 0);
        check("user_capture2", cap_cnt - c0, 2);
        tck(0, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_state", STATE, 4'hF);
        check("mid_rst_ir", IR, 4'h1);
        check("mid_rst_oe", TDO_OE, 1'b0);
        tck(1, 0); tck(1, 0);
        check("mid_rst_no_update", upd_cnt - u0, 1);
        check("mid_rst_tlr_hold", STATE, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
